// File: rtl/timer_ms_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ms_pkg
//  Description : Shared state encoding and sizing helpers for timer_ms_multi.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_ms_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

    localparam int C_MS_PER_S = 1000;

    function automatic int cyc_per_ms(input int clk_hz);
        return clk_hz / C_MS_PER_S;
    endfunction

    // Width of a counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_ms_channel.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ms_channel
//  Description : One millisecond timer channel: IDLE/RUN FSM, private ms
//                prescaler, latched duration and mode, registered done/busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_ms_channel
    import timer_ms_pkg::*;
#(
    parameter int CYC  = 100_000,
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            periodic,
    input  logic [BITS-1:0] final_value,
    output logic            done,
    output logic            busy
);

    localparam int             C_CW   = cnt_width(CYC);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(CYC - 1);
    localparam logic [C_CW-1:0] C_PRE  = C_CW'(CYC - 2);

    tmr_state_t      state_q, state_d;
    logic [C_CW-1:0] cyc_q,   cyc_d;
    logic [BITS-1:0] ms_q,    ms_d;
    logic [BITS-1:0] n_q,     n_d;
    logic            per_q,   per_d;
    logic            done_q,  done_d;
    logic            w_ms_last;

    assign w_ms_last = (ms_q == (n_q - BITS'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            ms_q    <= '0;
            n_q     <= '0;
            per_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ms_q    <= ms_d;
            n_q     <= n_d;
            per_q   <= per_d;
            done_q  <= done_d;
        end
    end

    // done is registered, so it is decided one cycle ahead of the expiry
    // cycle (cyc_cnt == CYC-2); a same-cycle stop/start therefore cancels it.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ms_d    = ms_q;
        n_d     = n_q;
        per_d   = per_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cyc_d   = '0;
            ms_d    = '0;
        end else if (start) begin
            n_d   = final_value;
            per_d = periodic;
            cyc_d = '0;
            ms_d  = '0;
            if (final_value == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            done_d = w_ms_last && (cyc_q == C_PRE);
            if (cyc_q == C_LAST) begin
                cyc_d = '0;
                if (w_ms_last) begin
                    ms_d = '0;
                    if (!per_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    ms_d = ms_q + BITS'(1);
                end
            end else begin
                cyc_d = cyc_q + C_CW'(1);
            end
        end
    end

    assign done = done_q;
    assign busy = (state_q == RUN);

endmodule
`default_nettype wire

// File: rtl/timer_ms_multi.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ms_multi
//  Description : CHANNELS independent millisecond timers with one-shot or
//                periodic mode; final_value carries one BITS-wide slice each.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_ms_multi
    import timer_ms_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int CHANNELS = 4,
    parameter int BITS     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      start,
    input  logic [CHANNELS-1:0]      stop,
    input  logic [CHANNELS-1:0]      periodic,
    input  logic [CHANNELS*BITS-1:0] final_value,
    output logic [CHANNELS-1:0]      done,
    output logic [CHANNELS-1:0]      busy
);

    localparam int C_CYC = cyc_per_ms(CLK_HZ);

    generate
        if ((CLK_HZ % C_MS_PER_S) != 0 || C_CYC < 2 ||
            CHANNELS < 1 || CHANNELS > 16) begin : g_bad_cfg
            $error("timer_ms_multi: CLK_HZ must be a multiple of 1000 with >= 2 cycles/ms, CHANNELS in 1..16");
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            timer_ms_channel #(
                .CYC  (C_CYC),
                .BITS (BITS)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .start       (start[gi]),
                .stop        (stop[gi]),
                .periodic    (periodic[gi]),
                .final_value (final_value[gi*BITS +: BITS]),
                .done        (done[gi]),
                .busy        (busy[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_timer_ms_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_ms_multi
//  Description : Directed, table-driven bench for timer_ms_multi (CYC = 10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_ms_multi;

    localparam int CLK_HZ = 10_000;
    localparam int CH     = 4;
    localparam int BITS   = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [CH-1:0]      start = '0;
    logic [CH-1:0]      stop = '0;
    logic [CH-1:0]      periodic = '0;
    logic [CH*BITS-1:0] final_value = '0;
    logic [CH-1:0]      done;
    logic [CH-1:0]      busy;

    int n_cmp = 0;
    int n_bad = 0;

    timer_ms_multi #(
        .CLK_HZ   (CLK_HZ),
        .CHANNELS (CH),
        .BITS     (BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .periodic    (periodic),
        .final_value (final_value),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // A record drives its inputs during cycle .cyc and, for channels in .chk,
    // expects busy == .exp_busy in that cycle; .exp_done lists the done pulses
    // due in that cycle (done is compared every cycle, zero unless listed).
    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [3:0] sp;
        logic [3:0] per;
        logic [31:0] fv;
        logic [3:0] chk;
        logic [3:0] exp_busy;
        logic [3:0] exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int cyc, input logic [3:0] st, input logic [3:0] sp,
                                input logic [3:0] per, input logic [31:0] fv,
                                input logic [3:0] chk, input logic [3:0] eb,
                                input logic [3:0] ed);
        vec_t v;
        v.cyc = cyc; v.st = st; v.sp = sp; v.per = per; v.fv = fv;
        v.chk = chk; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp,
                         input logic [3:0] mask, input int cyc);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b required %b (mask %b)", name, cyc, act, exp, mask);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = '0; stop = '0; periodic = '0; final_value = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run_table(input string name, input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            logic [3:0] ed;
            ed = '0;
            foreach (tbl[i]) begin
                if (tbl[i].cyc == c) begin
                    ed |= tbl[i].exp_done;
                    if (tbl[i].chk != 4'b0)
                        check({name, " busy"}, busy, tbl[i].exp_busy, tbl[i].chk, c);
                end
            end
            check({name, " done"}, done, ed, 4'hF, c);
            if (c < ncyc) begin
                start = '0;
                stop  = '0;
                foreach (tbl[i]) begin
                    if (tbl[i].cyc == c) begin
                        start |= tbl[i].st;
                        stop  |= tbl[i].sp;
                        for (int ch = 0; ch < CH; ch++) begin
                            if (tbl[i].st[ch]) begin
                                periodic[ch] = tbl[i].per[ch];
                                final_value[ch*BITS +: BITS] = tbl[i].fv[ch*8 +: 8];
                            end
                        end
                    end
                end
                step();
            end
        end
        start = '0;
        stop  = '0;
    endtask

    initial begin
        // One-shot on ch0, N=3 started in cycle 5.
        do_reset();
        tbl.delete();
        tbl.push_back(mk(0,  4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(mk(5,  4'b0001, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(6,  4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0001, 4'b0001, 4'b0000));
        tbl.push_back(mk(20, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0001, 4'b0001, 4'b0000));
        tbl.push_back(mk(35, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0001, 4'b0001, 4'b0001));
        tbl.push_back(mk(36, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0001, 4'b0000, 4'b0000));
        run_table("oneshot", 45);

        // Periodic on ch1, N=2 from cycle 0, stopped in cycle 50.
        do_reset();
        tbl.delete();
        tbl.push_back(mk(0,  4'b0010, 4'b0000, 4'b0010, {8'd0, 8'd0, 8'd2, 8'd0}, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(1,  4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0010, 4'b0010, 4'b0000));
        tbl.push_back(mk(20, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0010, 4'b0010, 4'b0010));
        tbl.push_back(mk(21, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0010, 4'b0010, 4'b0000));
        tbl.push_back(mk(40, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b0010));
        tbl.push_back(mk(50, 4'b0000, 4'b0010, 4'b0000, 32'h0, 4'b0010, 4'b0010, 4'b0000));
        tbl.push_back(mk(51, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0010, 4'b0000, 4'b0000));
        run_table("periodic", 70);

        // ch2 N=0 (periodic requested), ch3 N=255 one-shot, both started in cycle 2.
        do_reset();
        tbl.delete();
        tbl.push_back(mk(2,    4'b1100, 4'b0000, 4'b0100, {8'd255, 8'd0, 8'd0, 8'd0}, 4'b1100, 4'b0000, 4'b0000));
        tbl.push_back(mk(3,    4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b1100, 4'b1000, 4'b0100));
        tbl.push_back(mk(4,    4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(mk(2551, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b1000, 4'b1000, 4'b0000));
        tbl.push_back(mk(2552, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b1100, 4'b1000, 4'b1000));
        tbl.push_back(mk(2553, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b1000, 4'b0000, 4'b0000));
        run_table("zero_max", 2560);

        // Restarts, start+stop priority, and restart cancelling a pending expiry.
        do_reset();
        tbl.delete();
        tbl.push_back(mk(0,  4'b0101, 4'b0000, 4'b0000, {8'd0, 8'd1, 8'd0, 8'd5}, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(5,  4'b0010, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd1, 8'd0}, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(9,  4'b0100, 4'b0000, 4'b0000, {8'd0, 8'd1, 8'd0, 8'd0}, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(14, 4'b0010, 4'b0010, 4'b0000, {8'd0, 8'd0, 8'd1, 8'd0}, 4'b0010, 4'b0010, 4'b0000));
        tbl.push_back(mk(15, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0010, 4'b0000, 4'b0000));
        tbl.push_back(mk(19, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0100, 4'b0100, 4'b0100));
        tbl.push_back(mk(20, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(mk(30, 4'b0001, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd1}, 4'b0001, 4'b0001, 4'b0000));
        tbl.push_back(mk(40, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0001, 4'b0001, 4'b0001));
        tbl.push_back(mk(41, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0001, 4'b0000, 4'b0000));
        run_table("restart", 60);

        // All channels N=1 in the same cycle.
        do_reset();
        tbl.delete();
        tbl.push_back(mk(3,  4'b1111, 4'b0000, 4'b0000, {8'd1, 8'd1, 8'd1, 8'd1}, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(mk(13, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b1111, 4'b1111, 4'b1111));
        tbl.push_back(mk(14, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b1111, 4'b0000, 4'b0000));
        run_table("concurrent", 25);

        // Reset in cycle 17 with all channels periodic N=1, then a fresh start.
        do_reset();
        start = 4'b1111; periodic = 4'b1111; final_value = {4{8'd1}};
        step();
        start = '0;
        for (int c = 1; c <= 40; c++) begin
            check("rst done", done, (c == 10) ? 4'b1111 : 4'b0000, 4'hF, c);
            if (c == 17) check("rst busy", busy, 4'b1111, 4'hF, c);
            if (c >= 18) check("rst busy", busy, 4'b0000, 4'hF, c);
            reset = (c == 17);
            if (c == 40) begin
                start = 4'b0001; periodic = '0; final_value[7:0] = 8'd2;
            end
            step();
            start = '0;
        end
        for (int c = 41; c <= 62; c++) begin
            check("post-rst done", done, (c == 60) ? 4'b0001 : 4'b0000, 4'hF, c);
            if (c == 41 || c == 60) check("post-rst busy", busy, 4'b0001, 4'b0001, c);
            if (c == 61) check("post-rst busy", busy, 4'b0000, 4'b0001, c);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_ms_multi.md
# timer_ms_multi

Multi-channel millisecond timer that generalises the single-channel ms timer to `CHANNELS` independent channels. Each channel has its own start/stop control, one-shot or periodic mode, and a latched `BITS`-wide duration in milliseconds. Each channel has its own cycle-accurate ms prescaler, so expiry is exact relative to the start strobe. It sits beside the lab peripherals and supplies debounce windows, LED blink periods and sample intervals to control FSMs.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency; `CYC = CLK_HZ/1000` cycles per ms (must divide exactly, and `CYC >= 2`).
- `CHANNELS`, 4, number of independent timer channels (1..16).
- `BITS`, 16, width of each channel's ms duration.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high; all channels go IDLE.
- `start` in `CHANNELS`: per-channel start/restart strobe, level-sampled each cycle.
- `stop` in `CHANNELS`: per-channel abort strobe.
- `periodic` in `CHANNELS`: mode, sampled with `start` (1 = auto-reload, 0 = one-shot).
- `final_value` in `CHANNELS*BITS`: channel i occupies bits `[i*BITS +: BITS]`, duration in ms, sampled with `start`.
- `done` out `CHANNELS`: one-cycle expiry pulse per channel.
- `busy` out `CHANNELS`: channel is in RUN.

## Operation
- Per-channel FSM with states IDLE and RUN.
- Latching on `start`: on a cycle with `start[i]=1`, the channel latches `final_value` slice `N` and `periodic[i]`, clears both counters, and enters RUN. `stop` must not be high in that cycle (see priority).
- Counters per channel:
  - `cyc_cnt` is `$clog2(CYC)` bits and wraps at `CYC-1`.
  - `ms_cnt` is `BITS` bits and increments when `cyc_cnt` wraps.
  - Expiry occurs when `ms_cnt == N-1` and `cyc_cnt == CYC-1`.
- On expiry:
  - `done[i]` pulses.
  - Periodic: both counters clear and the channel stays in RUN.
  - One-shot: the channel returns to IDLE.
- `N == 0`: `done` pulses in the cycle after `start`, and the channel returns to IDLE regardless of `periodic`.
- `N == 2^BITS-1` is legal; no counter overflow is possible.
- `start` while in RUN restarts the channel with the newly latched values. A pending expiry in that same cycle is suppressed (no `done`).
- `stop` forces IDLE with no `done`.
  - Priority: `stop` > `start` > expiry.
  - `stop` in IDLE has no effect.
- Channels share no state; simultaneous events on different channels are independent.
- `reset` mid-count: next cycle all `busy=0`, `done=0`, and counters are cleared.

## Timing
- Reset values: `done=0`, `busy=0`, all counters 0, all channels IDLE.
- `start[i]` high in cycle k with `N>0`:
  - `busy[i]=1` from cycle k+1.
  - `done[i]=1` in exactly cycle k + N·CYC.
- Periodic mode: further `done` pulses at k + m·N·CYC for m = 2, 3, ….
- One-shot mode: `busy` stays 1 through the `done` cycle and is 0 from the next cycle.
- `N=0`: `done` in cycle k+1, and `busy` stays 0 throughout.
- `stop` in cycle j: `busy=0` from j+1. If `done` would have fired in j+1, it does not fire.
- Outputs are registered; no combinational path from any input to `done` or `busy`.

## Structure
- Package `timer_ms_pkg` holds:
  - `typedef enum logic {IDLE, RUN} tmr_state_t`;
  - function `cyc_per_ms(CLK_HZ)`;
  - localparam width helpers.
- Sub-module `timer_ms_channel`: one channel (FSM, `cyc_cnt`, `ms_cnt`, latches). The top instantiates it `CHANNELS` times in a generate loop and slices `final_value`.
- Elaboration-time assertion: `CLK_HZ % 1000 == 0`.

## Test plan
Bench uses `CLK_HZ=10_000` (`CYC=10`), `CHANNELS=4`, `BITS=8`.
- **One-shot:** reset, then ch0 start with N=3, periodic=0, in cycle 5 → `done[0]` only in cycle 35; `busy[0]` high in cycles 6–35 and low from 36.
- **Periodic:** ch1 start with N=2, periodic=1, at cycle 0 → `done[1]` at 20, 40, 60; `stop` at cycle 50 → no pulse at 60 and `busy` low from 51.
- **Zero and maximum duration:** ch2 N=0 → `done` at start+1 and `busy` never high; ch3 N=255 one-shot → single `done` at start+2550.
- **Restart and priority:** ch0 N=5 started at 0, restarted with N=1 at 30 → `done` at 40 only. A cycle with `start` and `stop` both high → channel IDLE, no `done`.
- **Reset mid-operation:** all four channels running, `reset` at cycle 17 → all outputs 0 from 18 and no `done` afterwards. Fresh starts after reset time correctly.
- **Concurrent channels:** all channels with N=1 started in the same cycle → four simultaneous `done` pulses at +10.
